// File: rtl/demosaic_pkg.sv
// Shared types for the Bayer ingest block: FSM states, CFA colours, patterns.
package demosaic_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CFA_R  = 2'd0,
    CFA_GR = 2'd1,
    CFA_GB = 2'd2,
    CFA_B  = 2'd3
  } cfa_t;

  localparam logic [1:0] PAT_RGGB = 2'd0;
  localparam logic [1:0] PAT_GRBG = 2'd1;
  localparam logic [1:0] PAT_GBRG = 2'd2;
  localparam logic [1:0] PAT_BGGR = 2'd3;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;

endpackage

// File: rtl/demosaic_cfa_phase.sv
// Maps (line parity, column parity, CFA pattern) to the colour of a sample.
module demosaic_cfa_phase
  import demosaic_pkg::*;
(
  input  logic       line_par,
  input  logic       col_par,
  input  logic [1:0] pat,
  output cfa_t       cfa
);

  logic [1:0] ph;

  // Each pattern is RGGB with its origin shifted by one row and/or column.
  always_comb begin
    ph  = {line_par, col_par} ^ pat;
    cfa = CFA_R;
    unique case (1'b1)
      ph == 2'b00: cfa = CFA_R;
      ph == 2'b01: cfa = CFA_GR;
      ph == 2'b10: cfa = CFA_GB;
      ph == 2'b11: cfa = CFA_B;
    endcase
  end

endmodule

// File: rtl/demosaic_bayer_ingest.sv
// Bayer ingest: frame/line tracking, CFA tagging and calibration-window prime.
// Define DEMOSAIC_INGEST_ERRCHK_EN to enable framing error detection on ERR.
module demosaic_bayer_ingest
  import demosaic_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned COLS        = 512,
  parameter int unsigned LINES       = 768,
  parameter int unsigned PRIME_LINES = 4,
  parameter int unsigned CFA_PAT     = 0
) (
  input  logic                     PCLK,
  input  logic                     rst,
  input  logic                     VSYNC,
  input  logic                     HSYNC,
  input  logic [DATA_W-1:0]        BAYERDATA,
  output logic [DATA_W-1:0]        O_DATA,
  output logic                     O_VALID,
  output logic [$clog2(COLS)-1:0]  O_COL,
  output logic [$clog2(LINES)-1:0] O_LINE,
  output logic [1:0]               O_CFA,
  output logic                     O_SOF,
  output logic                     O_EOL,
  output logic                     CAL_EN,
  output logic [1:0]               ERR
);

  localparam int unsigned CW = $clog2(COLS);
  localparam int unsigned LW = $clog2(LINES);

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [LW-1:0] LINE_LAST  = LW'(LINES - 1);
  localparam logic [LW-1:0] PRIME_LAST = LW'(PRIME_LINES - 1);
  localparam logic [1:0]    PAT        = 2'(CFA_PAT);

  state_t        state;
  logic          armed;
  logic [CW-1:0] col;
  logic [LW-1:0] line;

  logic run;
  logic start;
  logic drop;
  logic accept;
  logic wrap;
  logic short_close;
  logic line_close;
  cfa_t cfa;

  demosaic_cfa_phase u_phase (
    .line_par (line[0]),
    .col_par  (col[0]),
    .pat      (PAT),
    .cfa      (cfa)
  );

  always_comb begin
    run         = (state == PRIME) || (state == STREAM);
    start       = (state == IDLE) && armed && VSYNC;
    accept      = run && VSYNC && HSYNC && !drop;
    wrap        = accept && (col == COL_LAST);
    short_close = run && VSYNC && !HSYNC && (col != '0);
    line_close  = wrap || short_close;
  end

  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      armed   <= 1'b0;
      col     <= '0;
      line    <= '0;
      O_DATA  <= '0;
      O_VALID <= 1'b0;
      O_COL   <= '0;
      O_LINE  <= '0;
      O_CFA   <= CFA_R;
      O_SOF   <= 1'b0;
      O_EOL   <= 1'b0;
      CAL_EN  <= 1'b0;
    end else begin
      O_VALID <= accept;
      O_SOF   <= accept && (col == '0) && (line == '0);
      O_EOL   <= wrap;
      if (accept) begin
        O_DATA <= BAYERDATA;
        O_COL  <= col;
        O_LINE <= line;
        O_CFA  <= cfa;
      end
      // VSYNC low aborts from anywhere and arms the next frame start.
      if (!VSYNC) begin
        state  <= IDLE;
        armed  <= 1'b1;
        col    <= '0;
        line   <= '0;
        CAL_EN <= 1'b0;
      end else begin
        CAL_EN <= (state == STREAM) || (state == DONE);
        unique case (state)
          IDLE: begin
            if (start) begin
              state <= PRIME;
              armed <= 1'b0;
            end
          end
          PRIME, STREAM: begin
            if (accept) col <= wrap ? '0 : col + 1'b1;
            if (short_close) col <= '0;
            if (line_close) begin
              line <= (line == LINE_LAST) ? '0 : line + 1'b1;
              if (line == LINE_LAST) begin
                state <= DONE;
              end else if (line == PRIME_LAST && state == PRIME) begin
                state <= STREAM;
              end
            end
          end
          DONE: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef DEMOSAIC_INGEST_ERRCHK_EN
  logic       hold;
  logic [1:0] err;

  // hold: line already wrapped, swallow samples until HSYNC drops.
  always_ff @(posedge PCLK or posedge rst) begin
    if (rst) begin
      hold <= 1'b0;
      err  <= '0;
    end else if (!VSYNC) begin
      hold <= 1'b0;
      if (run) err <= err | ERR_SHORT;
    end else begin
      if (start) begin
        err <= '0;
      end else begin
        if (short_close) err[0] <= 1'b1;
        if (run && hold && HSYNC) err[1] <= 1'b1;
        if (state == DONE && HSYNC) err[1] <= 1'b1;
      end
      if (wrap) hold <= 1'b1;
      else if (!HSYNC) hold <= 1'b0;
    end
  end

  assign drop = hold;
  assign ERR  = err;
`else
  assign drop = 1'b0;
  assign ERR  = 2'b00;
`endif

endmodule
